serial_accumulator: RTL and testbench
=====================================

# serial_accumulator

- Serial arithmetic stage wrapped around the main store.
- Consumes the LSB-first word stream the store read unit drives on `w_MS_DATA_OUT`.
- Performs load-negative or subtract into an INSTR_BITS accumulator, or drives the accumulator back as the serial stream the store write unit samples.
- Framing matches the store: INSTR_BITS data beats plus FLYBACK_TIME idle beats per word, one beat per `w_DPG` edge.

## Interface
- INSTR_BITS, 20, word width; must match main store.
- FLYBACK_TIME, 4, idle beats per frame; must be ≥ 2.
- w_DPG  input  1  dot-pulse clock, all state on posedge.
- w_RESET  input  1  asynchronous, active-high reset.
- w_MS_DATA_OUT  input  1  serial store read data, bit k valid during beat k+1.
- b_ACC_OP  input  2  operation for next frame: 0 NOP, 1 LDN, 2 SUB, 3 STO.
- w_MS_DATA_IN  output  1  serial write data to store, bit k during beat k.
- b_ACC  output  INSTR_BITS  accumulator contents.
- w_ACC_NEG  output  1  accumulator sign, b_ACC[INSTR_BITS-1].
- w_ACC_DONE  output  1  one-beat pulse after a non-NOP frame completes.
- w_ACC_OVF  output  1  sticky signed-overflow flag (see Configuration).

## Operation
- Beat counter c runs 0 … INSTR_BITS+FLYBACK_TIME-1, then wraps to 0. It is free-running from reset.
- Op latch:
  - b_ACC_OP is sampled into op_q on the edge where c = INSTR_BITS+FLYBACK_TIME-1.
  - op_q governs the following frame only.
  - Changes at any other beat are ignored.
- Borrow flop is cleared on the edge where c = 0.
- On the edge where c = k+1 (k = 0 … INSTR_BITS-1), with m = w_MS_DATA_OUT:
  - LDN, a = 0: acc[k] ← a ^ m ^ b.
  - SUB, a = acc[k]: acc[k] ← a ^ m ^ b.
  - Borrow update for both: b ← (~a & m) | (~a & b) | (m & b).
  - NOP, STO: acc unchanged; input ignored.
- Arithmetic is modulo 2^INSTR_BITS, two's complement; the final borrow is discarded.
- STO output:
  - w_MS_DATA_IN = acc[c] when op_q = STO and c < INSTR_BITS.
  - Otherwise 0, including all flyback beats.
  - Combinational from registered state only.
- w_ACC_DONE is registered, high for the single beat following the edge at c = INSTR_BITS when op_q ≠ NOP.

## Timing
- Reset values: c = 0, op_q = NOP, borrow = 0, acc = 0, w_MS_DATA_IN = 0, w_ACC_NEG = 0, w_ACC_DONE = 0, w_ACC_OVF = 0.
- Reset mid-frame aborts the operation. The partially written acc is discarded and cleared.
- The first op is latched at the end of the first full frame after reset. The first frame after reset executes NOP.
- LDN/SUB latency: b_ACC final after the edge at c = INSTR_BITS. w_ACC_DONE is high during beat INSTR_BITS+1.
- STO: the store's write unit captures bit k on the edge at its counter = k. Counters are aligned when both leave reset/power-up together.
- Back-to-back ops in consecutive frames are permitted; there are no stall beats.
- SUB operand bits are read before being overwritten within the same edge.

## Configuration
- ACC_OVERFLOW_EN defined:
  - On the SUB/LDN edge at c = INSTR_BITS, w_ACC_OVF is set if the borrow into the sign bit differs from the borrow out.
  - The flag is sticky until w_RESET.
- ACC_OVERFLOW_EN undefined: the w_ACC_OVF port remains and is tied 0; no overflow logic is compiled.

## Structure
- Shared package serial_acc_pkg holds:
  - Op encodings ACC_OP_NOP / ACC_OP_LDN / ACC_OP_SUB / ACC_OP_STO.
  - The 2-bit op typedef.
- One sub-module, beat_counter, parameterised by INSTR_BITS and FLYBACK_TIME. Outputs c, first-beat strobe and last-beat strobe; reusable by the store units.

## Test plan
All scenarios use default parameters.
- **LDN:** acc = 0, store streams 5 → b_ACC = 0xFFFFB, w_ACC_NEG = 1, w_ACC_DONE pulses at beat 21.
- **SUB:** acc = 10, stream 3 → b_ACC = 7, w_ACC_NEG = 0. Then acc = 0, stream 1 → 0xFFFFF, w_ACC_NEG = 1.
- **STO:** acc = 0x12345 → w_MS_DATA_IN carries bits 1,0,1,0,0,0,1,0,1,1,0,0,0,1,0,0,1,0,0,0 on beats 0–19, then 0 on beats 20–23.
- **Overflow:** ACC_OVERFLOW_EN on, acc = 0x80000, SUB 1 → b_ACC = 0x7FFFF, w_ACC_OVF = 1 and stays set. Macro off → w_ACC_OVF = 0.
- **Op timing:** b_ACC_OP toggled to SUB at beat 5 and back to NOP at beat 10 → no effect. Held at beat 23 → next frame subtracts.
- **Reset mid-frame:** w_RESET asserted at beat 12 of a SUB → all outputs 0 immediately. After release, c restarts at 0 and the first frame is NOP.

Source files
------------

// File: rtl/serial_acc_pkg.sv
// Shared definitions for the serial accumulator and the main store units:
// accumulator op encodings, default framing and the serial borrow function.
package serial_acc_pkg;

  localparam int INSTR_BITS_DEFAULT   = 20;
  localparam int FLYBACK_TIME_DEFAULT = 4;

  typedef enum logic [1:0] {
    ACC_OP_NOP = 2'd0,
    ACC_OP_LDN = 2'd1,
    ACC_OP_SUB = 2'd2,
    ACC_OP_STO = 2'd3
  } acc_op_t;

  // Borrow out of one bit of a - m - b.
  function automatic logic borrow_out(input logic a, input logic m, input logic b);
    return (~a & m) | (~a & b) | (m & b);
  endfunction

endpackage

// File: rtl/beat_counter.sv
// Free-running beat counter for one store frame (data beats plus flyback),
// with strobes on the first and last beat; shared with the store units.
module beat_counter #(
  parameter int INSTR_BITS   = 20,
  parameter int FLYBACK_TIME = 4,
  parameter int CW           = $clog2(INSTR_BITS + FLYBACK_TIME)
) (
  input  logic          clk,
  input  logic          rst,
  output logic [CW-1:0] c,
  output logic          first,
  output logic          last
);

  localparam logic [CW-1:0] LAST_BEAT = CW'(INSTR_BITS + FLYBACK_TIME - 1);

  logic [CW-1:0] c_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      c_reg <= '0;
    else if (c_reg == LAST_BEAT)
      c_reg <= '0;
    else
      c_reg <= c_reg + CW'(1);
  end

  assign c     = c_reg;
  assign first = (c_reg == '0);
  assign last  = (c_reg == LAST_BEAT);

endmodule

// File: rtl/serial_accumulator.sv
// Bit-serial LDN/SUB/STO accumulator framed against the main store.
// Define ACC_OVERFLOW_EN to build the sticky signed-overflow flag.
module serial_accumulator
  import serial_acc_pkg::*;
#(
  parameter int INSTR_BITS   = INSTR_BITS_DEFAULT,
  parameter int FLYBACK_TIME = FLYBACK_TIME_DEFAULT
) (
  input  logic                  w_DPG,
  input  logic                  w_RESET,
  input  logic                  w_MS_DATA_OUT,
  input  logic [1:0]            b_ACC_OP,
  output logic                  w_MS_DATA_IN,
  output logic [INSTR_BITS-1:0] b_ACC,
  output logic                  w_ACC_NEG,
  output logic                  w_ACC_DONE,
  output logic                  w_ACC_OVF
);

  localparam int CW = $clog2(INSTR_BITS + FLYBACK_TIME);
  localparam logic [CW-1:0] SIGN_BEAT = CW'(INSTR_BITS);

  logic [CW-1:0]         c;
  logic                  first_beat;
  logic                  last_beat;
  acc_op_t               op_reg;
  logic                  borrow_reg, borrow_next;
  logic [INSTR_BITS-1:0] acc_reg, acc_next;
  logic                  done_reg;
  logic                  arith_beat;
  logic [CW-1:0]         bit_idx;
  logic                  a_bit;

  beat_counter #(
    .INSTR_BITS  (INSTR_BITS),
    .FLYBACK_TIME(FLYBACK_TIME),
    .CW          (CW)
  ) u_beat_counter (
    .clk  (w_DPG),
    .rst  (w_RESET),
    .c    (c),
    .first(first_beat),
    .last (last_beat)
  );

  // Store data bit k arrives on beat k+1, so the bit being updated lags c by one.
  assign arith_beat = ((op_reg == ACC_OP_LDN) || (op_reg == ACC_OP_SUB)) &&
                      (c != '0) && (c <= SIGN_BEAT);
  assign bit_idx    = c - CW'(1);

  always_comb begin
    acc_next    = acc_reg;
    borrow_next = borrow_reg;
    a_bit       = (op_reg == ACC_OP_SUB) ? acc_reg[bit_idx] : 1'b0;
    if (arith_beat) begin
      acc_next[bit_idx] = a_bit ^ w_MS_DATA_OUT ^ borrow_reg;
      borrow_next       = borrow_out(a_bit, w_MS_DATA_OUT, borrow_reg);
    end
  end

  always_ff @(posedge w_DPG or posedge w_RESET) begin
    if (w_RESET) begin
      op_reg     <= ACC_OP_NOP;
      borrow_reg <= 1'b0;
      acc_reg    <= '0;
      done_reg   <= 1'b0;
    end else begin
      if (last_beat)
        op_reg <= acc_op_t'(b_ACC_OP);
      borrow_reg <= first_beat ? 1'b0 : borrow_next;
      acc_reg    <= acc_next;
      done_reg   <= (c == SIGN_BEAT) && (op_reg != ACC_OP_NOP);
    end
  end

`ifdef ACC_OVERFLOW_EN
  logic ovf_reg;

  // Signed overflow: borrow into the sign bit differs from the borrow out of it.
  always_ff @(posedge w_DPG or posedge w_RESET) begin
    if (w_RESET)
      ovf_reg <= 1'b0;
    else if (arith_beat && (c == SIGN_BEAT) && (borrow_reg != borrow_next))
      ovf_reg <= 1'b1;
  end

  assign w_ACC_OVF = ovf_reg;
`else
  assign w_ACC_OVF = 1'b0;
`endif

  assign w_MS_DATA_IN = ((op_reg == ACC_OP_STO) && (c < SIGN_BEAT)) ? acc_reg[c] : 1'b0;
  assign b_ACC        = acc_reg;
  assign w_ACC_NEG    = acc_reg[INSTR_BITS-1];
  assign w_ACC_DONE   = done_reg;

endmodule

// File: tb/tb_serial_accumulator.sv
// Directed scoreboard bench for serial_accumulator at default parameters;
// expected overflow behaviour follows whether ACC_OVERFLOW_EN is defined.
module tb_serial_accumulator;
  import serial_acc_pkg::*;

  logic        w_DPG         = 1'b0;
  logic        w_RESET       = 1'b1;
  logic        w_MS_DATA_OUT = 1'b0;
  logic [1:0]  b_ACC_OP      = 2'd0;
  logic        w_MS_DATA_IN;
  logic [19:0] b_ACC;
  logic        w_ACC_NEG;
  logic        w_ACC_DONE;
  logic        w_ACC_OVF;

  int          tests = 0;
  int          fails = 0;
  int          tb_c  = 0;
  logic [19:0] model_acc = '0;
  logic        model_ovf = 1'b0;
  logic [19:0] acc_q[$];
  logic        bit_q[$];

  serial_accumulator dut (
    .w_DPG        (w_DPG),
    .w_RESET      (w_RESET),
    .w_MS_DATA_OUT(w_MS_DATA_OUT),
    .b_ACC_OP     (b_ACC_OP),
    .w_MS_DATA_IN (w_MS_DATA_IN),
    .b_ACC        (b_ACC),
    .w_ACC_NEG    (w_ACC_NEG),
    .w_ACC_DONE   (w_ACC_DONE),
    .w_ACC_OVF    (w_ACC_OVF)
  );

  always #5 w_DPG = ~w_DPG;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, required $finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_ovf();
`ifdef ACC_OVERFLOW_EN
    return model_ovf;
`else
    return 1'b0;
`endif
  endfunction

  task automatic step();
    @(posedge w_DPG);
    #1;
    tb_c = (tb_c == 23) ? 0 : tb_c + 1;
  endtask

  // Called with tb_c == 23: presents op for latching, then streams operand.
  task automatic frame(input acc_op_t op, input logic [19:0] operand, input string tag);
    logic [19:0] a;
    logic [19:0] r;
    logic        exp_bit;
    if (tb_c != 23) check({tag, "/align"}, tb_c, 23);
    b_ACC_OP = op;
    step();
    b_ACC_OP = ACC_OP_NOP;
    if (op == ACC_OP_LDN || op == ACC_OP_SUB) begin
      a = (op == ACC_OP_LDN) ? 20'h0 : model_acc;
      r = a - operand;
      if (a[19] != operand[19] && r[19] != a[19]) model_ovf = 1'b1;
      model_acc = r;
    end
    acc_q.push_back(model_acc);
    for (int i = 0; i < 24; i++)
      bit_q.push_back((op == ACC_OP_STO && i < 20) ? model_acc[i] : 1'b0);
    for (int i = 0; i < 24; i++) begin
      w_MS_DATA_OUT = (i >= 1 && i <= 20) ? operand[i-1] : 1'b0;
      exp_bit = bit_q.pop_front();
      check($sformatf("%s/ms_in%0d", tag, i), w_MS_DATA_IN, exp_bit);
      if (i == 20 || i == 22) check($sformatf("%s/done%0d", tag, i), w_ACC_DONE, 1'b0);
      if (i == 21) begin
        check({tag, "/done21"}, w_ACC_DONE, op != ACC_OP_NOP);
        check({tag, "/acc"}, b_ACC, acc_q.pop_front());
        check({tag, "/neg"}, w_ACC_NEG, model_acc[19]);
        check({tag, "/ovf"}, w_ACC_OVF, exp_ovf());
      end
      if (i < 23) step();
    end
    $display("[TB] frame %s op=%0d operand=%05h acc=%05h", tag, op, operand, b_ACC);
  endtask

  initial begin
    repeat (2) @(posedge w_DPG);
    #1;
    check("rst/acc", b_ACC, 20'h0);
    check("rst/neg", w_ACC_NEG, 1'b0);
    check("rst/done", w_ACC_DONE, 1'b0);
    check("rst/ovf", w_ACC_OVF, 1'b0);
    check("rst/ms_in", w_MS_DATA_IN, 1'b0);
    w_RESET = 1'b0;
    tb_c    = 0;

    // First frame runs NOP; op toggles away from the last beat are ignored.
    for (int i = 0; i < 23; i++) begin
      if (i == 5)  b_ACC_OP = ACC_OP_SUB;
      if (i == 10) b_ACC_OP = ACC_OP_NOP;
      w_MS_DATA_OUT = 1'b1;
      if (i == 21) begin
        check("first/done", w_ACC_DONE, 1'b0);
        check("first/acc", b_ACC, 20'h0);
      end
      step();
    end
    w_MS_DATA_OUT = 1'b0;
    $display("[TB] frame first_nop acc=%05h", b_ACC);

    frame(ACC_OP_LDN, 20'h00005, "ldn5");
    frame(ACC_OP_LDN, 20'hFFFF6, "ldn_m10");
    frame(ACC_OP_SUB, 20'h00003, "sub3");
    frame(ACC_OP_LDN, 20'h00000, "ldn0");
    frame(ACC_OP_SUB, 20'h00001, "sub1_neg");
    frame(ACC_OP_LDN, 20'hEDCBB, "ldn_12345");
    frame(ACC_OP_STO, 20'hA5A5A, "sto");
    frame(ACC_OP_NOP, 20'h55555, "nop");
    frame(ACC_OP_LDN, 20'h7FFFF, "ldn_7ffff");
    frame(ACC_OP_SUB, 20'h00001, "sub_to_80000");
    frame(ACC_OP_SUB, 20'h00001, "sub_ovf");
    frame(ACC_OP_NOP, 20'h00000, "ovf_hold");
    frame(ACC_OP_LDN, 20'h00001, "ovf_sticky");

    // Reset asserted at beat 12 of a SUB frame.
    b_ACC_OP = ACC_OP_SUB;
    step();
    b_ACC_OP = ACC_OP_NOP;
    for (int i = 0; i < 12; i++) begin
      w_MS_DATA_OUT = (i >= 1) ? 1'b1 : 1'b0;
      step();
    end
    #2;
    w_RESET = 1'b1;
    #1;
    check("midrst/acc", b_ACC, 20'h0);
    check("midrst/neg", w_ACC_NEG, 1'b0);
    check("midrst/done", w_ACC_DONE, 1'b0);
    check("midrst/ovf", w_ACC_OVF, 1'b0);
    check("midrst/ms_in", w_MS_DATA_IN, 1'b0);
    $display("[TB] mid-frame reset acc=%05h", b_ACC);
    @(posedge w_DPG);
    #1;
    w_RESET   = 1'b0;
    tb_c      = 0;
    model_acc = '0;
    model_ovf = 1'b0;
    acc_q.delete();
    bit_q.delete();

    // LDN held through the whole first frame after reset: only the last beat latches it.
    b_ACC_OP = ACC_OP_LDN;
    for (int i = 0; i < 23; i++) begin
      w_MS_DATA_OUT = 1'b1;
      if (i == 21) begin
        check("postrst/done", w_ACC_DONE, 1'b0);
        check("postrst/acc", b_ACC, 20'h0);
      end
      step();
    end
    w_MS_DATA_OUT = 1'b0;
    $display("[TB] frame post_reset_nop acc=%05h", b_ACC);
    frame(ACC_OP_LDN, 20'h00002, "postrst_ldn2");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
